// File: rtl/core_pkg.sv
// Shared core types: datapath width, ALU opcodes and the ID/EX ALU payload.
// Also holds RV32I opcode/funct7 constants used by the decode stage.
package core_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_XOR    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_AND    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // All-zero value is the reset payload (ALU_ADD encodes as 0)
    typedef struct packed {
        alu_sel_e              alu_sel;
        logic [DATA_WIDTH-1:0] operand1;
        logic [DATA_WIDTH-1:0] operand2;
        logic [4:0]            rd_addr;
        logic                  reg_write;
        logic                  alu_use;
        logic                  illegal;
    } alu_issue_t;

    function automatic alu_sel_e f3_to_sel(input logic [2:0] f3,
                                           input logic       alt);
        alu_sel_e sel;
        unique case (f3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I ALU-class decode: OP, OP-IMM, LUI, AUIPC into
// an ALU opcode plus resolved operands.
module alu_decoder
    import core_pkg::*;
(
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output alu_issue_t            issue_o
);

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;
    logic                  legal;
    logic                  shift;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign rd     = instr_i[11:7];
    assign imm_i  = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_u  = {{(DATA_WIDTH-32){instr_i[31]}}, instr_i[31:12], 12'b0};
    assign shift  = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        issue_o = '0;
        legal   = 1'b1;
        unique case (opcode)
            OPC_OP: begin
                legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                issue_o.alu_use  = 1'b1;
                issue_o.alu_sel  = f3_to_sel(f3, f7 == F7_ALT);
                issue_o.operand1 = rs1_data_i;
                issue_o.operand2 = rs2_data_i;
                issue_o.rd_addr  = rd;
            end
            OPC_OP_IMM: begin
                // Only shift-immediates reuse imm[11:5] as funct7
                legal = !shift || (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && (f3 == 3'b101));
                issue_o.alu_use  = 1'b1;
                issue_o.alu_sel  = f3_to_sel(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                issue_o.operand1 = rs1_data_i;
                issue_o.operand2 = imm_i;
                issue_o.rd_addr  = rd;
            end
            OPC_LUI: begin
                issue_o.alu_use  = 1'b1;
                issue_o.alu_sel  = ALU_PASS_B;
                issue_o.operand2 = imm_u;
                issue_o.rd_addr  = rd;
            end
            OPC_AUIPC: begin
                issue_o.alu_use  = 1'b1;
                issue_o.alu_sel  = ALU_ADD;
                issue_o.operand1 = pc_i;
                issue_o.operand2 = imm_u;
                issue_o.rd_addr  = rd;
            end
            default: begin
                issue_o = '0;
            end
        endcase

        if (issue_o.alu_use && !legal) begin
            issue_o.illegal  = 1'b1;
            issue_o.alu_sel  = ALU_ADD;
            issue_o.operand1 = '0;
            issue_o.operand2 = '0;
        end
        issue_o.reg_write = issue_o.alu_use && legal && (rd != 5'd0);
    end

endmodule

// File: rtl/id_alu_issue.sv
// ID/EX slot for the ALU: registers decoded ALU ops with stall/flush,
// feeding the EX-stage operand1/operand2/ALUSel interface.
module id_alu_issue
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output alu_sel_e              ALUSel_o,
    output logic [DATA_WIDTH-1:0] operand1_o,
    output logic [DATA_WIDTH-1:0] operand2_o,
    output logic [4:0]            rd_addr_o,
    output logic                  reg_write_o,
    output logic                  alu_use_o,
    output logic                  illegal_o
);

    alu_issue_t dec;
    alu_issue_t slot_d, slot_q;
    logic       valid_d, valid_q;

    alu_decoder u_dec (
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .issue_o    (dec)
    );

    // Flush beats stall; a bubble loads the reset payload
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (flush_i) begin
            valid_d = 1'b0;
            slot_d  = '0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            slot_d  = valid_i ? dec : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign ready_o     = !stall_i;
    assign valid_o     = valid_q;
    assign ALUSel_o    = slot_q.alu_sel;
    assign operand1_o  = slot_q.operand1;
    assign operand2_o  = slot_q.operand2;
    assign rd_addr_o   = slot_q.rd_addr;
    assign reg_write_o = slot_q.reg_write;
    assign alu_use_o   = slot_q.alu_use;
    assign illegal_o   = slot_q.illegal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Bench for id_alu_issue: vector table through a scoreboard queue,
// plus stall, flush and async reset sequences.
module tb_id_alu_issue;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic        stall_i, flush_i;
    logic        ready_o, valid_o;
    alu_sel_e    ALUSel_o;
    logic [31:0] operand1_o, operand2_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, alu_use_o, illegal_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        alu_sel_e    sel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        use_alu;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        vld;
        exp_t        e;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    exp_t sb_q [$];
    exp_t zero_e;
    exp_t held;

    id_alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .ALUSel_o    (ALUSel_o),
        .operand1_o  (operand1_o),
        .operand2_o  (operand2_o),
        .rd_addr_o   (rd_addr_o),
        .reg_write_o (reg_write_o),
        .alu_use_o   (alu_use_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(valid_o), 32'(e.valid));
        chk({tag, ".sel"}, 32'(ALUSel_o), 32'(e.sel));
        chk({tag, ".op1"}, operand1_o, e.op1);
        chk({tag, ".op2"}, operand2_o, e.op2);
        chk({tag, ".we"}, 32'(reg_write_o), 32'(e.we));
        chk({tag, ".ill"}, 32'(illegal_o), 32'(e.ill));
        // rd/alu_use of a malformed op are don't-care
        if (!e.ill) begin
            chk({tag, ".use"}, 32'(alu_use_o), 32'(e.use_alu));
            if (e.use_alu) chk({tag, ".rd"}, 32'(rd_addr_o), 32'(e.rd));
        end
    endtask

    task automatic drive(input vec_t v);
        valid_i    = v.vld;
        instr_i    = v.instr;
        pc_i       = v.pc;
        rs1_data_i = v.rs1;
        rs2_data_i = v.rs2;
        if (!stall_i && !flush_i) sb_q.push_back(v.e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=none required=entry", tag);
        end else begin
            e = sb_q.pop_front();
            held = e;
            cmp(tag, e);
        end
    endtask

    initial begin
        zero_e = '{1'b0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[0]  = '{32'h40B50533, 32'h0, 32'd9, 32'd4, 1'b1,
                     '{1'b1, ALU_SUB, 32'd9, 32'd4, 5'd10, 1'b1, 1'b1, 1'b0}};
        vecs[1]  = '{32'hFFF00293, 32'h4, 32'h0, 32'h55, 1'b1,
                     '{1'b1, ALU_ADD, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b1, 1'b0}};
        vecs[2]  = '{32'h40335313, 32'h8, 32'h80000000, 32'h1, 1'b1,
                     '{1'b1, ALU_SRA, 32'h80000000, 32'h403, 5'd6, 1'b1, 1'b1, 1'b0}};
        vecs[3]  = '{32'h12345097, 32'h100, 32'h77, 32'h88, 1'b1,
                     '{1'b1, ALU_ADD, 32'h100, 32'h12345000, 5'd1, 1'b1, 1'b1, 1'b0}};
        vecs[4]  = '{32'h00001037, 32'h104, 32'h77, 32'h88, 1'b1,
                     '{1'b1, ALU_PASS_B, 32'h0, 32'h1000, 5'd0, 1'b0, 1'b1, 1'b0}};
        vecs[5]  = '{32'h02B50533, 32'h108, 32'd9, 32'd4, 1'b1,
                     '{1'b1, ALU_ADD, 32'h0, 32'h0, 5'd10, 1'b0, 1'b1, 1'b1}};
        vecs[6]  = '{32'h002141B3, 32'h10C, 32'hAAAA0000, 32'h0000FFFF, 1'b1,
                     '{1'b1, ALU_XOR, 32'hAAAA0000, 32'h0000FFFF, 5'd3, 1'b1, 1'b1, 1'b0}};
        vecs[7]  = '{32'h80013213, 32'h110, 32'h7, 32'h0, 1'b1,
                     '{1'b1, ALU_SLTU, 32'h7, 32'hFFFFF800, 5'd4, 1'b1, 1'b1, 1'b0}};
        vecs[8]  = '{32'h409453B3, 32'h114, 32'hF0000000, 32'd4, 1'b1,
                     '{1'b1, ALU_SRA, 32'hF0000000, 32'd4, 5'd7, 1'b1, 1'b1, 1'b0}};
        vecs[9]  = '{32'h0000A283, 32'h118, 32'h1234, 32'h5678, 1'b1,
                     '{1'b1, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{32'h40309113, 32'h11C, 32'h1, 32'h2, 1'b1,
                     '{1'b1, ALU_ADD, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1}};
        vecs[11] = '{32'h40B50533, 32'h120, 32'd9, 32'd4, 1'b0, zero_e};

        rst_n = 1'b0;
        valid_i = 1'b0;
        instr_i = '0;
        pc_i = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #12;
        cmp("reset", zero_e);
        chk("reset.ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            pop_cmp($sformatf("vec%0d", i));
        end

        // stall: A held for 3 cycles while B is presented
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1;
        pop_cmp("stallA");
        @(negedge clk);
        stall_i = 1'b1;
        drive(vecs[6]);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d.ready", c), 32'(ready_o), 32'd0);
            @(posedge clk);
            #1;
            cmp($sformatf("stall%0d.hold", c), held);
            @(negedge clk);
        end
        stall_i = 1'b0;
        drive(vecs[6]);
        #1;
        chk("unstall.ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        pop_cmp("stallB");

        // stall and flush together: flush wins
        @(negedge clk);
        stall_i = 1'b1;
        flush_i = 1'b1;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        cmp("flush", zero_e);
        @(negedge clk);
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(vecs[3]);
        @(posedge clk);
        #1;
        pop_cmp("postflush");

        // async reset mid-cycle while stalled
        @(negedge clk);
        stall_i = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("asyncrst", zero_e);
        @(negedge clk);
        rst_n = 1'b1;
        stall_i = 1'b0;
        drive(vecs[2]);
        @(posedge clk);
        #1;
        pop_cmp("postrst");

        chk("sb.empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
